// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer at BASE_ADDR..BASE_ADDR+3 with a one-clock overflow IRQ.
// Define TIMER_OVERFLOW_DELAY_EN for the 4-clk delayed reload and its collision rules.
module gb_timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  t_cycle,
  input  logic [15:0] bus_addr,
  input  logic        bus_enable,
  input  logic        bus_write,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        bus_hit,
  output logic        timer_irq
);

  logic [15:0] div_reg;
  logic [7:0]  tima_reg;
  logic [7:0]  tma_reg;
  logic [2:0]  tac_reg;
  logic        s_prev_reg;
  logic        irq_reg;

`ifdef TIMER_OVERFLOW_DELAY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_OVF, ST_RELOAD} state_t;
  state_t      state_reg;
  logic [1:0]  cnt_reg;
`endif

  logic [15:0] offset;
  logic [1:0]  sel;
  logic        commit;
  logic        wr_div, wr_tima, wr_tma, wr_tac;
  logic [15:0] div_next;
  logic [2:0]  tac_next;
  logic [7:0]  tma_next;
  logic        s_next;
  logic        tick;

  assign offset  = bus_addr - BASE_ADDR;
  assign sel     = offset[1:0];
  assign bus_hit = bus_enable && (offset[15:2] == 14'd0);
  assign commit  = bus_hit && bus_write && (t_cycle == 2'd3);
  assign wr_div  = commit && (sel == 2'd0);
  assign wr_tima = commit && (sel == 2'd1);
  assign wr_tma  = commit && (sel == 2'd2);
  assign wr_tac  = commit && (sel == 2'd3);

  assign div_next = wr_div ? 16'h0000 : div_reg + 16'd1;
  assign tac_next = wr_tac ? bus_wdata[2:0] : tac_reg;
  assign tma_next = wr_tma ? bus_wdata : tma_reg;

  function automatic logic tick_level(input logic [2:0] tac, input logic [15:0] div);
    logic bit_sel;
    case (tac[1:0])
      2'd0:    bit_sel = div[9];
      2'd1:    bit_sel = div[3];
      2'd2:    bit_sel = div[5];
      default: bit_sel = div[7];
    endcase
    return tac[2] & bit_sel;
  endfunction

  // The tick level is taken from the post-edge register values, so a DIV or
  // TAC write that drops it counts on the very edge it commits.
  assign s_next = tick_level(tac_next, div_next);
  assign tick   = s_prev_reg & ~s_next;

  always_comb begin
    bus_rdata = 8'hFF;
    if (bus_hit) begin
      case (sel)
        2'd0:    bus_rdata = div_reg[15:8];
        2'd1:    bus_rdata = tima_reg;
        2'd2:    bus_rdata = tma_reg;
        default: bus_rdata = {5'b11111, tac_reg};
      endcase
    end
  end

  assign timer_irq = irq_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg    <= 16'h0000;
      tima_reg   <= 8'h00;
      tma_reg    <= 8'h00;
      tac_reg    <= 3'b000;
      s_prev_reg <= 1'b0;
      irq_reg    <= 1'b0;
`ifdef TIMER_OVERFLOW_DELAY_EN
      state_reg  <= ST_IDLE;
      cnt_reg    <= 2'd0;
`endif
    end else begin
      div_reg    <= div_next;
      tac_reg    <= tac_next;
      tma_reg    <= tma_next;
      s_prev_reg <= s_next;
      irq_reg    <= 1'b0;
`ifdef TIMER_OVERFLOW_DELAY_EN
      case (state_reg)
        ST_IDLE: begin
          if (wr_tima) begin
            tima_reg <= bus_wdata;
          end else if (tick) begin
            if (tima_reg == 8'hFF) begin
              tima_reg  <= 8'h00;
              cnt_reg   <= 2'd0;
              state_reg <= ST_OVF;
            end else begin
              tima_reg <= tima_reg + 8'd1;
            end
          end
        end
        ST_OVF: begin
          // A CPU write to TIMA during the delay cancels the pending reload.
          if (wr_tima) begin
            tima_reg  <= bus_wdata;
            state_reg <= ST_IDLE;
          end else if (cnt_reg == 2'd3) begin
            tima_reg  <= tma_next;
            irq_reg   <= 1'b1;
            state_reg <= ST_RELOAD;
          end else begin
            cnt_reg <= cnt_reg + 2'd1;
            if (tick) tima_reg <= tima_reg + 8'd1;
          end
        end
        default: begin
          // Reload cycle: TIMA writes are dropped, TMA writes pass through.
          if (wr_tma) begin
            tima_reg <= bus_wdata;
          end else if (tick) begin
            tima_reg <= tima_reg + 8'd1;
          end
          state_reg <= ST_IDLE;
        end
      endcase
`else
      if (wr_tima) begin
        tima_reg <= bus_wdata;
      end else if (tick) begin
        if (tima_reg == 8'hFF) begin
          tima_reg <= tma_next;
          irq_reg  <= 1'b1;
        end else begin
          tima_reg <= tima_reg + 8'd1;
        end
      end
`endif
    end
  end

endmodule
